lenet_conv_channel_gen: RTL and testbench
=========================================

# lenet_conv_channel_gen

Parametrised LeNet convolution output-channel block: runs IN_CH parallel 5x5 `conv_engine` instances over IN_CH input feature maps and sums their results with a signed 16-bit bias. It then requantises the sum (shift, ReLU, clamp to 0..127) and optionally 2x2 max-pools it through `maxpool_engine`. Weights and bias arrive over a runtime-reloadable stream instead of a fixed ROM. The block is the generic successor used for every conv layer after layer 1, one instance per output channel.

## Interface
- IN_CH, 6: number of input channels / conv engines (1..16).
- MAPSIZE, 14: input map width = height; conv output is (MAPSIZE-4)x(MAPSIZE-4).
- OUTPUT_SHIFT, 8: arithmetic right shift applied to the biased sum.
- POOL_EN, 1: 1 = output through `maxpool_engine` (MAP_WIDTH=MAPSIZE-4); 0 = bypass pooling.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame start request; honoured only in IDLE.
- reload  in  1  request new weight/bias load.
- wt_valid  in  1  weight stream word valid.
- wt_data  in  8 signed  weight stream word.
- wt_ready  out  1  block accepts a word when wt_valid && wt_ready.
- weights_ready  out  1  weights and bias loaded, block in IDLE or RUN.
- data_valid_in  in  IN_CH  per-channel pixel valid.
- pixel_in  in  IN_CH x 8 signed  per-channel pixel.
- data_valid_out  out  1  output pixel valid.
- pixel_out  out  8 signed  output pixel, 0..127.
- layer_done  out  1  one-cycle pulse with the last output pixel of a frame.
- sync_err  out  1  sticky flag: engine valid outputs disagreed.

## Operation
- States: LOAD, IDLE, RUN.
- Reset enters LOAD. Reset clears all counters, the reload latch and sync_err. All outputs reset to 0.
- LOAD:
  - wt_ready=1.
  - Accepts IN_CH*25 weights in order channel, row, col (col fastest), then bias low byte, then bias high byte.
  - Uses explicit ch/row/col counters; no divide or modulo.
  - After the last accepted word, go to IDLE and set weights_ready=1.
- IDLE:
  - reload=1 goes to LOAD and clears weights_ready; reload has priority over start in the same cycle.
  - start=1 goes to RUN and clears sync_err.
- RUN:
  - A registered internal start pulses to all engines for one cycle, the cycle after start.
  - On layer_done, return to IDLE.
  - reload during RUN is latched. After layer_done the block goes to LOAD instead of IDLE. The frame is never aborted.
- start outside IDLE is dropped, not queued.
- Words with wt_valid outside LOAD are ignored.
- Weight updates never occur outside LOAD.
- Arithmetic:
  - Sum the IN_CH 32-bit engine outputs in 32-bit signed.
  - Add the bias, sign-extended to 32 bits.
  - Shift right arithmetically by OUTPUT_SHIFT.
  - Result <0 gives 0; >127 gives 127; otherwise low 8 bits.
- Valid is taken from engine 0. In any cycle where the engine mem_wr_en bits are not all equal, set sync_err; it holds until rst or the next accepted start.
- POOL_EN=0: an output counter counts (MAPSIZE-4)^2 valid pixels. layer_done is asserted with the last one, and the counter wraps to 0.

## Timing
- Pipeline: the engine output is registered as the biased sum (stage 1), then as the quantised pixel (stage 2).
- POOL_EN=0: data_valid_out is 2 cycles after engine mem_wr_en.
- POOL_EN=1: add `maxpool_engine` latency; layer_done comes from the pool.
- wt_ready falls the cycle after the final bias byte is accepted. weights_ready rises that same cycle.
- Reset mid-LOAD or mid-RUN discards partial weights and frame state. Stored weight register contents are don't-care until reloaded.
- Full rate: one pixel per cycle per channel, with no backpressure on outputs.

## Test plan
- Reset: after rst, all outputs 0. wt_ready=1 on the first cycle after rst deasserts; weights_ready=0; start is ignored (no data_valid_out).
- IN_CH=6, POOL_EN=0, shift 8:
  - Load weights all 1, bias 0x0100 (bytes 0x00, 0x01).
  - Start, then stream 196 pixels of value 1 on all channels.
  - Expect 100 outputs of 1 (150+256=406, >>8 = 1), with layer_done on the 100th.
- Same setup, bias 0x8000 (-32768): 100 outputs of 0 (ReLU).
- Saturation: weights 127, pixels 127, bias 0, POOL_EN=1: 6*25*16129 >>8 = 9450 clamps to 127. Expect 25 pooled outputs of 127 and layer_done on the last.
- Reload in RUN:
  - Assert reload mid-frame: all 100 outputs still appear.
  - After layer_done, weights_ready=0 and wt_ready=1.
  - start during LOAD produces no output.
- Misalignment: delay data_valid_in[0] one cycle relative to the other channels. Expect sync_err=1, held until the next accepted start clears it.

Source files
------------

// File: rtl/lenet_conv_channel_gen.sv
`default_nettype none
// ============================================================================
// lenet_conv_channel_gen : one LeNet conv output channel (IN_CH 5x5 engines,
//                          bias, requantise, optional 2x2 max-pool)
// Revision 1.0
// ============================================================================

module conv_engine #(
    parameter int MAPSIZE = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [199:0]       weights,
    input  logic               data_valid,
    input  logic signed [7:0]  pixel,
    output logic               mem_wr_en,
    output logic signed [31:0] result
);
    localparam int SR_LEN = 4*MAPSIZE + 5;
    localparam int CW     = $clog2(MAPSIZE);
    localparam logic [CW-1:0] FOUR = CW'(4);
    localparam logic [CW-1:0] LAST = CW'(MAPSIZE-1);

    logic signed [7:0]  taps [SR_LEN];
    logic [CW-1:0]      col;
    logic [CW-1:0]      row;
    logic               active;
    logic               win_ok;
    logic signed [31:0] mac;
    logic signed [31:0] wv;
    logic signed [31:0] pv;

    // taps[0] is the newest pixel; taps[r*MAPSIZE+c] is r rows and c cols back
    always_ff @(posedge clk) begin
        if (active && data_valid) begin
            taps[0] <= pixel;
            for (int k = 1; k < SR_LEN; k++) taps[k] <= taps[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            col    <= '0;
            row    <= '0;
            win_ok <= 1'b0;
        end else begin
            win_ok <= active && data_valid && (row >= FOUR) && (col >= FOUR);
            if (start) begin
                active <= 1'b1;
                col    <= '0;
                row    <= '0;
            end else if (active && data_valid) begin
                if (col == LAST) begin
                    col <= '0;
                    if (row == LAST) begin
                        row    <= '0;
                        active <= 1'b0;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    always_comb begin
        mac = '0;
        wv  = '0;
        pv  = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                wv  = 32'(signed'(weights[(i*5+j)*8 +: 8]));
                pv  = 32'(taps[(4-i)*MAPSIZE + (4-j)]);
                mac = mac + wv * pv;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wr_en <= 1'b0;
            result    <= '0;
        end else begin
            mem_wr_en <= win_ok;
            if (win_ok) result <= mac;
        end
    end
endmodule

module maxpool_engine #(
    parameter int MAP_WIDTH = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              data_valid,
    input  logic signed [7:0] pixel,
    output logic              data_valid_out,
    output logic signed [7:0] pixel_out,
    output logic              layer_done
);
    localparam int CW   = $clog2(MAP_WIDTH);
    localparam int HALF = MAP_WIDTH / 2;
    localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST      = CW'(MAP_WIDTH-1);
    localparam logic [CW-1:0] LAST_EVEN = CW'(HALF*2-1);

    logic [CW-1:0]     col;
    logic [CW-1:0]     row;
    logic [HW-1:0]     pc;
    logic signed [7:0] hold;
    logic signed [7:0] line [HALF];
    logic signed [7:0] hmax;
    logic signed [7:0] vmax;
    logic              take;

    assign take = data_valid && !start;

    always_comb begin
        hmax = (pixel > hold) ? pixel : hold;
        vmax = (hmax > line[pc]) ? hmax : line[pc];
    end

    // Even rows park their horizontal pair maxima; odd rows finish the 2x2 window
    always_ff @(posedge clk) begin
        if (take && col[0] && !row[0]) line[pc] <= hmax;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col            <= '0;
            row            <= '0;
            pc             <= '0;
            hold           <= '0;
            data_valid_out <= 1'b0;
            pixel_out      <= '0;
            layer_done     <= 1'b0;
        end else begin
            data_valid_out <= 1'b0;
            layer_done     <= 1'b0;
            if (start) begin
                col <= '0;
                row <= '0;
                pc  <= '0;
            end else if (take) begin
                if (!col[0]) begin
                    hold <= pixel;
                end else begin
                    if (row[0]) begin
                        data_valid_out <= 1'b1;
                        pixel_out      <= vmax;
                        layer_done     <= (row == LAST_EVEN) && (col == LAST_EVEN);
                    end
                    pc <= pc + 1'b1;
                end
                if (col == LAST) begin
                    col <= '0;
                    pc  <= '0;
                    row <= (row == LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end
endmodule

module lenet_conv_channel_gen #(
    parameter int IN_CH        = 6,
    parameter int MAPSIZE      = 14,
    parameter int OUTPUT_SHIFT = 8,
    parameter int POOL_EN      = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   reload,
    input  logic                   wt_valid,
    input  logic signed [7:0]      wt_data,
    output logic                   wt_ready,
    output logic                   weights_ready,
    input  logic [IN_CH-1:0]       data_valid_in,
    input  logic [IN_CH-1:0][7:0]  pixel_in,
    output logic                   data_valid_out,
    output logic signed [7:0]      pixel_out,
    output logic                   layer_done,
    output logic                   sync_err
);
    localparam int CONV_W = MAPSIZE - 4;
    localparam int NPIX   = CONV_W * CONV_W;
    localparam int OC_W   = $clog2(NPIX + 1);
    localparam int CH_W   = (IN_CH > 1) ? $clog2(IN_CH) : 1;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        IDLE = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                        state;
    state_t                        state_next;
    logic [IN_CH-1:0][4:0][4:0][7:0] wt_mem;
    logic [15:0]                   bias;
    logic [CH_W-1:0]               ld_ch;
    logic [2:0]                    ld_row;
    logic [2:0]                    ld_col;
    logic [1:0]                    ld_phase;
    logic                          wt_take;
    logic                          load_last;
    logic                          start_ok;
    logic                          reload_lat;
    logic                          eng_start;
    logic [IN_CH-1:0]              eng_valid;
    logic [IN_CH-1:0][31:0]        eng_res;
    logic signed [31:0]            sum_c;
    logic signed [31:0]            sum_q;
    logic signed [31:0]            shifted;
    logic [7:0]                    quant_c;
    logic                          s1_valid;
    logic                          s2_valid;
    logic [7:0]                    s2_pix;

    assign wt_ready      = (state == LOAD) && !rst;
    assign weights_ready = ((state == IDLE) || (state == RUN)) && !rst;
    assign wt_take       = wt_valid && wt_ready;
    assign load_last     = wt_take && (ld_phase == 2'd2);
    assign start_ok      = (state == IDLE) && start && !reload;

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (load_last) state_next = IDLE;
            IDLE:    if (reload) state_next = LOAD;
                     else if (start) state_next = RUN;
            RUN:     if (layer_done) state_next = (reload_lat || reload) ? LOAD : IDLE;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            reload_lat <= 1'b0;
            eng_start  <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_next;
            eng_start  <= start_ok;
            reload_lat <= (state == RUN) && !layer_done && (reload_lat || reload);
            if (start_ok)
                sync_err <= 1'b0;
            else if ((|eng_valid) && !(&eng_valid))
                sync_err <= 1'b1;
        end
    end

    // Stream order: weights by channel/row/col, then bias low byte, bias high byte
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_ch    <= '0;
            ld_row   <= '0;
            ld_col   <= '0;
            ld_phase <= '0;
        end else if (wt_take) begin
            case (ld_phase)
                2'd0: begin
                    if (ld_col == 3'd4) begin
                        ld_col <= '0;
                        if (ld_row == 3'd4) begin
                            ld_row <= '0;
                            if (ld_ch == CH_W'(IN_CH-1)) begin
                                ld_ch    <= '0;
                                ld_phase <= 2'd1;
                            end else begin
                                ld_ch <= ld_ch + 1'b1;
                            end
                        end else begin
                            ld_row <= ld_row + 1'b1;
                        end
                    end else begin
                        ld_col <= ld_col + 1'b1;
                    end
                end
                2'd1:    ld_phase <= 2'd2;
                default: ld_phase <= 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wt_take) begin
            case (ld_phase)
                2'd0:    wt_mem[ld_ch][ld_row][ld_col] <= wt_data;
                2'd1:    bias[7:0]  <= wt_data;
                default: bias[15:8] <= wt_data;
            endcase
        end
    end

    for (genvar g = 0; g < IN_CH; g++) begin : g_eng
        conv_engine #(.MAPSIZE(MAPSIZE)) u_eng (
            .clk        (clk),
            .rst        (rst),
            .start      (eng_start),
            .weights    (wt_mem[g]),
            .data_valid (data_valid_in[g]),
            .pixel      (pixel_in[g]),
            .mem_wr_en  (eng_valid[g]),
            .result     (eng_res[g])
        );
    end

    always_comb begin
        sum_c = 32'(signed'(bias));
        for (int g = 0; g < IN_CH; g++) sum_c = sum_c + signed'(eng_res[g]);
        shifted = sum_q >>> OUTPUT_SHIFT;
        if (shifted < 0)
            quant_c = 8'd0;
        else if (shifted > 32'sd127)
            quant_c = 8'd127;
        else
            quant_c = shifted[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q    <= '0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s2_pix   <= '0;
        end else begin
            s1_valid <= eng_valid[0];
            if (eng_valid[0]) sum_q <= sum_c;
            s2_valid <= s1_valid;
            if (s1_valid) s2_pix <= quant_c;
        end
    end

    if (POOL_EN != 0) begin : g_pool
        maxpool_engine #(.MAP_WIDTH(CONV_W)) u_pool (
            .clk            (clk),
            .rst            (rst),
            .start          (eng_start),
            .data_valid     (s2_valid),
            .pixel          (s2_pix),
            .data_valid_out (data_valid_out),
            .pixel_out      (pixel_out),
            .layer_done     (layer_done)
        );
    end else begin : g_nopool
        logic [OC_W-1:0] out_cnt;
        logic            done_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                out_cnt <= '0;
                done_q  <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (s1_valid) begin
                    if (out_cnt == OC_W'(NPIX-1)) begin
                        out_cnt <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        out_cnt <= out_cnt + 1'b1;
                    end
                end
            end
        end

        assign data_valid_out = s2_valid;
        assign pixel_out      = s2_pix;
        assign layer_done     = done_q;
    end
endmodule

`default_nettype wire

// File: tb/tb_lenet_conv_channel_gen.sv
`default_nettype none
// Bench for lenet_conv_channel_gen: two instances (unpooled and pooled) share
// all inputs and are checked against an arithmetic convolution/pool model.
module tb_lenet_conv_channel_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            start;
    logic            reload;
    logic            wt_valid;
    logic [7:0]      wt_data;
    logic [5:0]      dv_in;
    logic [5:0][7:0] pix_in;

    logic       dvo   [2];
    logic [7:0] pout  [2];
    logic       ldone [2];
    logic       wrdy  [2];
    logic       wsr   [2];
    logic       serr  [2];

    lenet_conv_channel_gen #(.IN_CH(6), .MAPSIZE(14), .OUTPUT_SHIFT(8), .POOL_EN(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .reload(reload),
        .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wrdy[0]), .weights_ready(wsr[0]),
        .data_valid_in(dv_in), .pixel_in(pix_in),
        .data_valid_out(dvo[0]), .pixel_out(pout[0]), .layer_done(ldone[0]), .sync_err(serr[0])
    );

    lenet_conv_channel_gen #(.IN_CH(6), .MAPSIZE(14), .OUTPUT_SHIFT(8), .POOL_EN(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .reload(reload),
        .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wrdy[1]), .weights_ready(wsr[1]),
        .data_valid_in(dv_in), .pixel_in(pix_in),
        .data_valid_out(dvo[1]), .pixel_out(pout[1]), .layer_done(ldone[1]), .sync_err(serr[1])
    );

    int W [6][5][5];
    int P [6][14][14];
    int bias_v;
    int checks = 0;
    int errors = 0;

    // Observed / expected output streams: {layer_done, pixel}; 8'hFF marks a done without valid
    logic [8:0] got0 [$];
    logic [8:0] got1 [$];
    logic [8:0] exp0 [$];
    logic [8:0] exp1 [$];
    int done_cnt0 = 0;
    int done_cnt1 = 0;
    int sb0, sb1;

    always @(negedge clk) begin
        if (!rst) begin
            if (dvo[0] || ldone[0]) begin
                got0.push_back({ldone[0], dvo[0] ? pout[0] : 8'hFF});
                if (ldone[0]) done_cnt0++;
            end
            if (dvo[1] || ldone[1]) begin
                got1.push_back({ldone[1], dvo[1] ? pout[1] : 8'hFF});
                if (ldone[1]) done_cnt1++;
            end
        end
    end

    function automatic void build_expected();
        int conv [10][10];
        int s;
        int m;
        logic [8:0] e;
        exp0.delete();
        exp1.delete();
        for (int y = 0; y < 10; y++) begin
            for (int x = 0; x < 10; x++) begin
                s = 0;
                for (int c = 0; c < 6; c++)
                    for (int i = 0; i < 5; i++)
                        for (int j = 0; j < 5; j++)
                            s += W[c][i][j] * P[c][y+i][x+j];
                s = (s + bias_v) >>> 8;
                if (s < 0) s = 0;
                if (s > 127) s = 127;
                conv[y][x] = s;
                e[8]   = (y == 9) && (x == 9);
                e[7:0] = s[7:0];
                exp0.push_back(e);
            end
        end
        for (int py = 0; py < 5; py++) begin
            for (int px = 0; px < 5; px++) begin
                m = conv[2*py][2*px];
                if (conv[2*py][2*px+1]   > m) m = conv[2*py][2*px+1];
                if (conv[2*py+1][2*px]   > m) m = conv[2*py+1][2*px];
                if (conv[2*py+1][2*px+1] > m) m = conv[2*py+1][2*px+1];
                e[8]   = (py == 4) && (px == 4);
                e[7:0] = m[7:0];
                exp1.push_back(e);
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_weights();
        logic [7:0] words [$];
        for (int c = 0; c < 6; c++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    words.push_back(8'(W[c][i][j]));
        words.push_back(bias_v[7:0]);
        words.push_back(bias_v[15:8]);
        for (int k = 0; k < words.size(); k++) begin
            while ($urandom_range(0, 3) == 0) begin
                wt_valid = 1'b0;
                wt_data  = 8'($urandom);
                tick();
            end
            wt_valid = 1'b1;
            wt_data  = words[k];
            tick();
        end
        wt_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (wrdy[d] !== 1'b0 || wsr[d] !== 1'b1) begin
                errors++;
                $display("FAIL load_done[%0d]: wt_ready=%b weights_ready=%b, required 0/1", d, wrdy[d], wsr[d]);
            end
        end
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        load_weights();
    endtask

    task automatic run_frame(input string tag, input bit gaps, input bit skew, input bit mid_reload);
        int b0, b1, t, last_k, idx;
        b0 = done_cnt0;
        b1 = done_cnt1;
        sb0 = got0.size();
        sb1 = got1.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        last_k = skew ? 196 : 195;
        for (int k = 0; k <= last_k; k++) begin
            if (gaps) begin
                while ($urandom_range(0, 4) == 0) begin
                    dv_in  = '0;
                    pix_in = {2{24'($urandom)}};
                    tick();
                end
            end
            for (int ch = 0; ch < 6; ch++) begin
                idx = (skew && ch == 0) ? k - 1 : k;
                if (idx >= 0 && idx < 196) begin
                    dv_in[ch]  = 1'b1;
                    pix_in[ch] = 8'(P[ch][idx / 14][idx % 14]);
                end else begin
                    dv_in[ch]  = 1'b0;
                    pix_in[ch] = 8'($urandom);
                end
            end
            reload = mid_reload && (k == 60);
            if (mid_reload) begin
                wt_valid = 1'b1;
                wt_data  = 8'($urandom);
            end
            tick();
        end
        dv_in    = '0;
        reload   = 1'b0;
        wt_valid = 1'b0;
        t = 0;
        while ((done_cnt0 == b0 || done_cnt1 == b1) && t < 300) begin
            tick();
            t++;
        end
        checks++;
        if (t >= 300) begin
            errors++;
            $display("FAIL %s_timeout: done counts %0d/%0d, required %0d/%0d", tag, done_cnt0 - b0, done_cnt1 - b1, 1, 1);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({dvo[d], pout[d], ldone[d], wrdy[d], wsr[d], serr[d]} !== 13'd0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: dv=%b px=%0d ld=%b wr=%b wsr=%b se=%b, required all 0",
                         d, dvo[d], pout[d], ldone[d], wrdy[d], wsr[d], serr[d]);
            end
        end
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (wrdy[d] !== 1'b1 || wsr[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_load[%0d]: wt_ready=%b weights_ready=%b, required 1/0", d, wrdy[d], wsr[d]);
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            dv_in  = '1;
            pix_in = {2{24'($urandom)}};
            tick();
        end
        dv_in = '0;
        repeat (10) tick();
        checks++;
        if (got0.size() != 0 || got1.size() != 0) begin
            errors++;
            $display("FAIL reset_start_ignored: outputs %0d/%0d, required 0/0", got0.size(), got1.size());
        end
    endtask

    task automatic test_ones();
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) W[c][i][j] = 1;
            for (int r = 0; r < 14; r++) for (int q = 0; q < 14; q++) P[c][r][q] = 1;
        end
        bias_v = 256;
        load_weights();
        build_expected();
        run_frame("ones", 1'b0, 1'b0, 1'b0);
        checks++;
        if (got0.size() - sb0 != exp0.size() || got1.size() - sb1 != exp1.size()) begin
            errors++;
            $display("FAIL ones_count: got %0d/%0d, required %0d/%0d", got0.size() - sb0, got1.size() - sb1, exp0.size(), exp1.size());
        end
        for (int k = 0; k < exp0.size() && sb0 + k < got0.size(); k++) begin
            checks++;
            if (got0[sb0+k] !== exp0[k]) begin
                errors++;
                $display("FAIL ones_nopool[%0d]: got %h, required %h", k, got0[sb0+k], exp0[k]);
            end
        end
        for (int k = 0; k < exp1.size() && sb1 + k < got1.size(); k++) begin
            checks++;
            if (got1[sb1+k] !== exp1[k]) begin
                errors++;
                $display("FAIL ones_pool[%0d]: got %h, required %h", k, got1[sb1+k], exp1[k]);
            end
        end
    endtask

    task automatic test_relu();
        // reload and start together: reload wins, block must be in LOAD
        reload = 1'b1;
        start  = 1'b1;
        tick();
        reload = 1'b0;
        start  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (wrdy[d] !== 1'b1 || wsr[d] !== 1'b0) begin
                errors++;
                $display("FAIL relu_reload_priority[%0d]: wt_ready=%b weights_ready=%b, required 1/0", d, wrdy[d], wsr[d]);
            end
        end
        bias_v = -32768;
        load_weights();
        build_expected();
        run_frame("relu", 1'b1, 1'b0, 1'b0);
        checks++;
        if (got0.size() - sb0 != exp0.size() || got1.size() - sb1 != exp1.size()) begin
            errors++;
            $display("FAIL relu_count: got %0d/%0d, required %0d/%0d", got0.size() - sb0, got1.size() - sb1, exp0.size(), exp1.size());
        end
        for (int k = 0; k < exp0.size() && sb0 + k < got0.size(); k++) begin
            checks++;
            if (got0[sb0+k] !== exp0[k]) begin
                errors++;
                $display("FAIL relu_nopool[%0d]: got %h, required %h", k, got0[sb0+k], exp0[k]);
            end
        end
        for (int k = 0; k < exp1.size() && sb1 + k < got1.size(); k++) begin
            checks++;
            if (got1[sb1+k] !== exp1[k]) begin
                errors++;
                $display("FAIL relu_pool[%0d]: got %h, required %h", k, got1[sb1+k], exp1[k]);
            end
        end
    endtask

    task automatic test_saturation();
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) W[c][i][j] = 127;
            for (int r = 0; r < 14; r++) for (int q = 0; q < 14; q++) P[c][r][q] = 127;
        end
        bias_v = 0;
        do_reload();
        build_expected();
        run_frame("sat", 1'b0, 1'b0, 1'b0);
        checks++;
        if (got0.size() - sb0 != exp0.size() || got1.size() - sb1 != exp1.size()) begin
            errors++;
            $display("FAIL sat_count: got %0d/%0d, required %0d/%0d", got0.size() - sb0, got1.size() - sb1, exp0.size(), exp1.size());
        end
        for (int k = 0; k < exp0.size() && sb0 + k < got0.size(); k++) begin
            checks++;
            if (got0[sb0+k] !== exp0[k]) begin
                errors++;
                $display("FAIL sat_nopool[%0d]: got %h, required %h", k, got0[sb0+k], exp0[k]);
            end
        end
        for (int k = 0; k < exp1.size() && sb1 + k < got1.size(); k++) begin
            checks++;
            if (got1[sb1+k] !== exp1[k]) begin
                errors++;
                $display("FAIL sat_pool[%0d]: got %h, required %h", k, got1[sb1+k], exp1[k]);
            end
        end
    endtask

    task automatic randomize_model();
        logic signed [15:0] b16;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) W[c][i][j] = int'($urandom_range(0, 8)) - 4;
            for (int r = 0; r < 14; r++) for (int q = 0; q < 14; q++) P[c][r][q] = int'($urandom_range(0, 63)) - 16;
        end
        b16    = 16'($urandom);
        bias_v = b16;
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            randomize_model();
            do_reload();
            build_expected();
            run_frame("rand", 1'b1, 1'b0, 1'b0);
            checks++;
            if (got0.size() - sb0 != exp0.size() || got1.size() - sb1 != exp1.size()) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d/%0d, required %0d/%0d", it, got0.size() - sb0, got1.size() - sb1, exp0.size(), exp1.size());
            end
            for (int k = 0; k < exp0.size() && sb0 + k < got0.size(); k++) begin
                checks++;
                if (got0[sb0+k] !== exp0[k]) begin
                    errors++;
                    $display("FAIL rand%0d_nopool[%0d]: got %h, required %h", it, k, got0[sb0+k], exp0[k]);
                end
            end
            for (int k = 0; k < exp1.size() && sb1 + k < got1.size(); k++) begin
                checks++;
                if (got1[sb1+k] !== exp1[k]) begin
                    errors++;
                    $display("FAIL rand%0d_pool[%0d]: got %h, required %h", it, k, got1[sb1+k], exp1[k]);
                end
            end
        end
    endtask

    task automatic test_reload_in_run();
        int n0, n1;
        // weights stay as loaded; junk words stream during the frame and must be ignored
        for (int c = 0; c < 6; c++)
            for (int r = 0; r < 14; r++) for (int q = 0; q < 14; q++) P[c][r][q] = int'($urandom_range(0, 63)) - 16;
        build_expected();
        run_frame("rrun", 1'b1, 1'b0, 1'b1);
        checks++;
        if (got0.size() - sb0 != exp0.size() || got1.size() - sb1 != exp1.size()) begin
            errors++;
            $display("FAIL rrun_count: got %0d/%0d, required %0d/%0d", got0.size() - sb0, got1.size() - sb1, exp0.size(), exp1.size());
        end
        for (int k = 0; k < exp0.size() && sb0 + k < got0.size(); k++) begin
            checks++;
            if (got0[sb0+k] !== exp0[k]) begin
                errors++;
                $display("FAIL rrun_nopool[%0d]: got %h, required %h", k, got0[sb0+k], exp0[k]);
            end
        end
        for (int k = 0; k < exp1.size() && sb1 + k < got1.size(); k++) begin
            checks++;
            if (got1[sb1+k] !== exp1[k]) begin
                errors++;
                $display("FAIL rrun_pool[%0d]: got %h, required %h", k, got1[sb1+k], exp1[k]);
            end
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (wrdy[d] !== 1'b1 || wsr[d] !== 1'b0) begin
                errors++;
                $display("FAIL rrun_to_load[%0d]: wt_ready=%b weights_ready=%b, required 1/0", d, wrdy[d], wsr[d]);
            end
        end
        n0 = got0.size();
        n1 = got1.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 196; k++) begin
            dv_in = '1;
            for (int ch = 0; ch < 6; ch++) pix_in[ch] = 8'(P[ch][k / 14][k % 14]);
            tick();
        end
        dv_in = '0;
        repeat (10) tick();
        checks++;
        if (got0.size() != n0 || got1.size() != n1) begin
            errors++;
            $display("FAIL load_start_ignored: outputs %0d/%0d, required 0/0", got0.size() - n0, got1.size() - n1);
        end
        load_weights();
    endtask

    task automatic test_misalign();
        run_frame("skew", 1'b0, 1'b1, 1'b0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (serr[d] !== 1'b1) begin
                errors++;
                $display("FAIL sync_err_set[%0d]: got %b, required 1", d, serr[d]);
            end
        end
        repeat (8) tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (serr[d] !== 1'b1) begin
                errors++;
                $display("FAIL sync_err_hold[%0d]: got %b, required 1", d, serr[d]);
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (serr[d] !== 1'b0) begin
                errors++;
                $display("FAIL sync_err_clear[%0d]: got %b, required 0", d, serr[d]);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        reload   = 1'b0;
        wt_valid = 1'b0;
        wt_data  = '0;
        dv_in    = '0;
        pix_in   = '0;
        test_reset();
        test_ones();
        test_relu();
        test_saturation();
        test_random();
        test_reload_in_run();
        test_misalign();
        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
